// File: rtl/video_scandoubler_pkg.sv
// Shared pixel/sync definitions for the 15kHz -> 31kHz line doubler.
// Colour width, sync polarity and the scanline dimming codes live here.
package video_scandoubler_pkg;

  localparam int RGB_W = 6;
  localparam int PIX_W = 3 * RGB_W;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    SL_OFF = 2'b00,
    SL_25  = 2'b01,
    SL_50  = 2'b10,
    SL_75  = 2'b11
  } scan_mode_e;

endpackage

// File: rtl/video_scandoubler_linebuf.sv
// Two-bank line buffer: one write port, one read port with a registered output.
// The bank select is the top address bit, so write and read banks never collide.
module video_linebuf #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 18
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_scandoubler.sv
// Line doubler: records each core video line into one bank and replays the previous
// line twice at the 2x pixel rate, with optional dimming of every second output line.
module video_scandoubler
  import video_scandoubler_pkg::*;
#(
  parameter int HCNT_W = 10,
  parameter int HS_MIN = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             ce_x1,
  input  logic             ce_x2,
  input  logic             bypass,
  input  logic [1:0]       scanlines,
  input  logic [RGB_W-1:0] R_in,
  input  logic [RGB_W-1:0] G_in,
  input  logic [RGB_W-1:0] B_in,
  input  logic             HSync,
  input  logic             VSync,
  output logic [RGB_W-1:0] R_out,
  output logic [RGB_W-1:0] G_out,
  output logic [RGB_W-1:0] B_out,
  output logic             HSync_out,
  output logic             VSync_out
);

  localparam int LEN_W = HCNT_W + 1;
  localparam logic [LEN_W-1:0]  LINE_MAX = {1'b1, {HCNT_W{1'b0}}};
  localparam logic [HCNT_W-1:0] HS_MIN_C = HCNT_W'(HS_MIN);
  localparam logic [HCNT_W-1:0] HS_SAT   = '1;

  logic              r_hs_d;
  logic              r_wr_bank;
  logic              r_armed;
  logic              r_vs_lat;
  logic [LEN_W-1:0]  r_hcnt_in;
  logic [LEN_W-1:0]  r_line_len;
  logic [HCNT_W-1:0] r_hs_cnt;
  logic [HCNT_W-1:0] r_hs_width;
  logic [HCNT_W-1:0] r_hcnt_out;
  logic              r_odd;

  logic              r_vld_p1;
  logic              r_odd_p1;
  logic              r_blank_p1;
  logic              r_hs_p1;
  logic              r_vs_p1;

  logic              w_hs_fall;
  logic              w_we;
  logic              w_wbank;
  logic [HCNT_W-1:0] w_waddr;
  logic              w_line_ok;
  logic [LEN_W-1:0]  w_last;
  logic [PIX_W-1:0]  w_rd_data;
  scan_mode_e        w_mode;

  function automatic logic [RGB_W-1:0] f_dim(input logic [RGB_W-1:0] c,
                                             input scan_mode_e mode,
                                             input logic odd);
    logic [RGB_W-1:0] q;
    q = c;
    if (odd) begin
      case (mode)
        SL_OFF:  q = c;
        SL_25:   q = c - (c >> 2);
        SL_50:   q = c >> 1;
        SL_75:   q = c >> 2;
        default: q = c;
      endcase
    end
    return q;
  endfunction

  // The pixel on the HSync falling edge is pixel 0 of the new line, so it goes
  // straight into the freshly selected bank.
  assign w_hs_fall = ce_x1 & r_hs_d & ~HSync;
  assign w_wbank   = w_hs_fall ? ~r_wr_bank : r_wr_bank;
  assign w_waddr   = w_hs_fall ? '0 : r_hcnt_in[HCNT_W-1:0];
  assign w_we      = ce_x1 & (w_hs_fall | (r_hcnt_in < LINE_MAX));
  assign w_line_ok = (r_line_len != '0);
  assign w_last    = r_line_len - LEN_W'(1);
  assign w_mode    = scan_mode_e'(scanlines);

  video_linebuf #(
    .ADDR_W(LEN_W),
    .DATA_W(PIX_W)
  ) u_linebuf (
    .i_clk  (clk_sys),
    .i_we   (w_we),
    .i_waddr({w_wbank, w_waddr}),
    .i_wdata({R_in, G_in, B_in}),
    .i_re   (ce_x2),
    .i_raddr({~r_wr_bank, r_hcnt_out}),
    .o_rdata(w_rd_data)
  );

  // Input side. The first edge after reset only arms the recorder: the line
  // before it is partial and is never replayed.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d     <= SYNC_IDLE;
      r_wr_bank  <= 1'b0;
      r_armed    <= 1'b0;
      r_vs_lat   <= SYNC_IDLE;
      r_hcnt_in  <= '0;
      r_line_len <= '0;
      r_hs_cnt   <= '0;
      r_hs_width <= '0;
    end else if (ce_x1) begin
      r_hs_d <= HSync;
      if (w_hs_fall) begin
        r_hcnt_in  <= LEN_W'(1);
        r_wr_bank  <= ~r_wr_bank;
        r_armed    <= 1'b1;
        if (r_armed) r_line_len <= r_hcnt_in;
        r_hs_width <= (r_hs_cnt < HS_MIN_C) ? HS_MIN_C : r_hs_cnt;
        r_hs_cnt   <= HCNT_W'(1);
        r_vs_lat   <= VSync;
      end else begin
        if (r_hcnt_in < LINE_MAX) r_hcnt_in <= r_hcnt_in + LEN_W'(1);
        if (HSync == SYNC_ACTIVE && r_hs_cnt != HS_SAT) r_hs_cnt <= r_hs_cnt + HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt_out <= '0;
      r_odd      <= 1'b0;
    end else if (w_hs_fall) begin
      r_hcnt_out <= '0;
      r_odd      <= 1'b0;
    end else if (ce_x2) begin
      if (!w_line_ok) begin
        r_hcnt_out <= '0;
      end else if ({1'b0, r_hcnt_out} == w_last) begin
        r_hcnt_out <= '0;
        r_odd      <= ~r_odd;
      end else begin
        r_hcnt_out <= r_hcnt_out + HCNT_W'(1);
      end
    end
  end

  // p1: read issued, line attributes travel alongside the buffer read
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_odd_p1   <= 1'b0;
      r_blank_p1 <= 1'b1;
      r_hs_p1    <= SYNC_IDLE;
      r_vs_p1    <= SYNC_IDLE;
    end else begin
      r_vld_p1 <= ce_x2;
      if (ce_x2) begin
        r_odd_p1   <= r_odd;
        r_blank_p1 <= ~w_line_ok;
        r_hs_p1    <= (w_line_ok && r_hcnt_out < r_hs_width) ? SYNC_ACTIVE : SYNC_IDLE;
        if (r_hcnt_out == '0) r_vs_p1 <= r_vs_lat;
      end
    end
  end

  // p2: output register, either the straight input or the dimmed replay
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
      HSync_out <= SYNC_IDLE;
      VSync_out <= SYNC_IDLE;
    end else if (bypass) begin
      if (ce_x1) begin
        R_out     <= R_in;
        G_out     <= G_in;
        B_out     <= B_in;
        HSync_out <= HSync;
        VSync_out <= VSync;
      end
    end else if (r_vld_p1) begin
      R_out     <= r_blank_p1 ? '0 : f_dim(w_rd_data[PIX_W-1 -: RGB_W], w_mode, r_odd_p1);
      G_out     <= r_blank_p1 ? '0 : f_dim(w_rd_data[2*RGB_W-1 -: RGB_W], w_mode, r_odd_p1);
      B_out     <= r_blank_p1 ? '0 : f_dim(w_rd_data[RGB_W-1:0], w_mode, r_odd_p1);
      HSync_out <= r_hs_p1;
      VSync_out <= r_vs_p1;
    end
  end

endmodule

// File: tb/tb_video_scandoubler.sv
// Directed bench for video_scandoubler: drives whole core lines and checks the
// doubled output of the previously driven line against a small line model.
module tb_video_scandoubler;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_x1 = 1'b0;
  logic       ce_x2 = 1'b1;
  logic       bypass = 1'b0;
  logic [1:0] scanlines = 2'b00;
  logic [5:0] R_in = '0, G_in = '0, B_in = '0;
  logic       HSync = 1'b1, VSync = 1'b1;
  logic [5:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;
  int prev_len = 0;
  int prev_hs = 0;
  logic [17:0] prev_pix [1100];
  logic [17:0] cur_pix [1100];

  always #5 clk_sys = ~clk_sys;

  video_scandoubler #(.HCNT_W(10), .HS_MIN(8)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce_x1(ce_x1), .ce_x2(ce_x2),
    .bypass(bypass), .scanlines(scanlines),
    .R_in(R_in), .G_in(G_in), .B_in(B_in), .HSync(HSync), .VSync(VSync),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSync_out(HSync_out), .VSync_out(VSync_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [17:0] pat(input int mode, input int j);
    logic [10:0] jj;
    jj = 11'(j);
    case (mode)
      0:       return {jj[5:0], jj[5:0], jj[5:0]};
      1:       return {3{6'h3C}};
      default: return {jj[5:0], jj[10:5], ~jj[5:0]};
    endcase
  endfunction

  // Hand-written dimming table: 25% keeps 3/4, 50% halves, 75% keeps 1/4.
  function automatic logic [5:0] dimc(input logic [5:0] c, input logic [1:0] sl);
    case (sl)
      2'b01:   return c - {2'b00, c[5:2]};
      2'b10:   return {1'b0, c[5:1]};
      2'b11:   return {2'b00, c[5:2]};
      default: return c;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ce_x1 = (i % 2 == 0);
      HSync = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
  endtask

  // One core line of len pixels (2*len clocks). rst_at >= 0 asserts reset at that clock.
  task automatic run_line(input int len, input int hs_w, input logic vs,
                          input int mode, input int rst_at);
    int j, k, lp, a, hsw;
    logic odd;
    logic [17:0] p, e;
    edges++;
    for (int i = 0; i < len; i++) cur_pix[i] = pat(mode, i);
    lp  = (prev_len > 1024) ? 1024 : prev_len;
    hsw = (prev_hs < 8) ? 8 : prev_hs;
    for (int m = 0; m < 2 * len; m++) begin
      j = m / 2;
      ce_x1 = (m % 2 == 0);
      {R_in, G_in, B_in} = cur_pix[j];
      HSync = (j < hs_w) ? 1'b0 : 1'b1;
      VSync = vs;
      if (m == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", {14'd0, R_out, G_out, B_out}, 32'd0);
        chk("async_rst_hs", {31'd0, HSync_out}, 32'd1);
        chk("async_rst_vs", {31'd0, VSync_out}, 32'd1);
        return;
      end
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (bypass) begin
        chk("bypass_rgb", {14'd0, R_out, G_out, B_out}, {14'd0, cur_pix[j]});
        chk("bypass_hs", {31'd0, HSync_out}, {31'd0, HSync});
        chk("bypass_vs", {31'd0, VSync_out}, {31'd0, vs});
      end else if (m >= 2) begin
        k = m - 2;
        if (edges < 2) begin
          chk("blank_rgb", {14'd0, R_out, G_out, B_out}, 32'd0);
          chk("blank_hs", {31'd0, HSync_out}, 32'd1);
        end else begin
          a   = k % lp;
          odd = ((k / lp) % 2) == 1;
          p   = prev_pix[a];
          e   = odd ? {dimc(p[17:12], scanlines), dimc(p[11:6], scanlines), dimc(p[5:0], scanlines)} : p;
          chk("replay_rgb", {14'd0, R_out, G_out, B_out}, {14'd0, e});
          chk("replay_hs", {31'd0, HSync_out}, (a < hsw) ? 32'd0 : 32'd1);
        end
        chk("replay_vs", {31'd0, VSync_out}, {31'd0, vs});
      end
    end
    prev_pix = cur_pix;
    prev_len = len;
    prev_hs  = hs_w;
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    idle(4);
    chk("reset_rgb", {14'd0, R_out, G_out, B_out}, 32'd0);
    chk("reset_hs", {31'd0, HSync_out}, 32'd1);
    chk("reset_vs", {31'd0, VSync_out}, 32'd1);
    rst_n = 1'b1;
    idle(4);

    // first line only arms the recorder; second replays a 320-pixel ramp
    run_line(320, 24, 1'b1, 0, -1);
    run_line(320, 24, 1'b1, 0, -1);

    // scanlines 50%, 75%, 25% on constant 6'h3C
    scanlines = 2'b10;
    run_line(320, 24, 1'b1, 1, -1);
    run_line(320, 24, 1'b1, 1, -1);
    scanlines = 2'b11;
    run_line(320, 24, 1'b1, 1, -1);
    scanlines = 2'b01;
    run_line(320, 3, 1'b1, 0, -1);
    scanlines = 2'b00;

    // 3-tick HSync -> widened to 8
    run_line(320, 3, 1'b1, 0, -1);

    // VSync low for three lines
    run_line(320, 24, 1'b0, 0, -1);
    run_line(320, 24, 1'b0, 0, -1);
    run_line(320, 24, 1'b0, 0, -1);
    run_line(320, 24, 1'b1, 0, -1);

    // bypass passthrough, then doubling of the line written during bypass
    bypass = 1'b1;
    run_line(200, 24, 1'b1, 2, -1);
    bypass = 1'b0;
    run_line(320, 24, 1'b1, 0, -1);

    // over-long lines truncated to 1024
    run_line(1100, 24, 1'b1, 2, -1);
    run_line(1100, 24, 1'b1, 2, -1);

    // reset mid-line, then outputs stay blank until a full line is recorded
    run_line(320, 24, 1'b1, 1, 101);
    idle(4);
    chk("midrst_rgb", {14'd0, R_out, G_out, B_out}, 32'd0);
    rst_n = 1'b1;
    edges = 0;
    idle(4);
    run_line(320, 24, 1'b1, 0, -1);
    run_line(320, 24, 1'b1, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
